// File: rtl/alu_writeback.sv
// ---------------------------------------------------------------------------
// alu_writeback
//   Return path of the ALU datapath. ALU results tagged with a destination
//   register are buffered in a small flop-based FIFO and drained into the
//   8x32 register-file write port at one entry per cycle. A per-register
//   in-flight counter (scoreboard) tracks writes that were dispatched but not
//   yet retired. The command controller uses pending_mask to stall on hazards.
//
// Ports:
//   clk, rst        rising-edge clock, asynchronous active-high reset
//   issue_valid     controller dispatched an op this cycle (reserve)
//   issue_dest      destination register of the dispatched op
//   res_valid       ALU result available
//   res_ready       FIFO can accept a result
//   res_data        ALU result data
//   res_dest        destination register of the result
//   res_op          opcode that produced the result
//   wb_stall        register file cannot accept a write this cycle
//   rf_we           register-file write enable (registered)
//   rf_waddr        register-file write address (registered)
//   rf_wdata        register-file write data (registered)
//   pending_mask    bit i set while register i has writes in flight
//   fifo_count      current FIFO occupancy
//   zero_flag       last written data was zero
//   neg_flag        bit 31 of last written data
//   err             sticky scoreboard over/underflow error
// ---------------------------------------------------------------------------
module alu_writeback #(
    parameter int          DEPTH   = 4,
    parameter int          CNT_W   = 3,
    parameter logic [2:0]  HALT_OP = 3'b111
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      issue_valid,
    input  logic [2:0]                issue_dest,
    input  logic                      res_valid,
    output logic                      res_ready,
    input  logic [31:0]               res_data,
    input  logic [2:0]                res_dest,
    input  logic [2:0]                res_op,
    input  logic                      wb_stall,
    output logic                      rf_we,
    output logic [2:0]                rf_waddr,
    output logic [31:0]               rf_wdata,
    output logic [7:0]                pending_mask,
    output logic [$clog2(DEPTH):0]    fifo_count,
    output logic                      zero_flag,
    output logic                      neg_flag,
    output logic                      err
);

    localparam int              PTR_W      = $clog2(DEPTH);
    localparam int              CW         = PTR_W + 1;
    localparam logic [CW-1:0]   FULL_COUNT = CW'(DEPTH);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;

    // FIFO storage (no reset needed: only entries below fifo_count are read)
    logic [31:0]      mem_data [DEPTH];
    logic [2:0]       mem_dest [DEPTH];
    logic [2:0]       mem_op   [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;

    logic             do_push;
    logic             do_pop;
    logic [31:0]      head_data;
    logic [2:0]       head_dest;
    logic [2:0]       head_op;

    // Scoreboard
    logic [CNT_W-1:0] cnt     [8];
    logic [CNT_W-1:0] cnt_nxt [8];
    logic [7:0]       rsv_vec;
    logic [7:0]       rel_vec;
    logic             err_set;

    // Handshake: a result transfers on any rising edge where res_valid and
    // res_ready are both high. res_ready depends only on the registered
    // occupancy, never on res_valid, so the producer may hold res_valid and
    // its payload until it sees the transfer.
    assign res_ready = (fifo_count != FULL_COUNT);
    assign do_push   = res_valid && res_ready;
    // Pop uses the registered count, so an entry pushed at an edge can only
    // leave at a later edge.
    assign do_pop    = (fifo_count != '0) && !wb_stall;

    assign head_data = mem_data[rd_ptr];
    assign head_dest = mem_dest[rd_ptr];
    assign head_op   = mem_op[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_data[wr_ptr] <= res_data;
            mem_dest[wr_ptr] <= res_dest;
            mem_op[wr_ptr]   <= res_op;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({do_push, do_pop})
                2'b10:   fifo_count <= fifo_count + CW'(1);
                2'b01:   fifo_count <= fifo_count - CW'(1);
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    // Write port and flags. HALT entries retire silently: no write, flags kept.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rf_we     <= 1'b0;
            rf_waddr  <= '0;
            rf_wdata  <= '0;
            zero_flag <= 1'b0;
            neg_flag  <= 1'b0;
        end else if (do_pop && (head_op != HALT_OP)) begin
            rf_we     <= 1'b1;
            rf_waddr  <= head_dest;
            rf_wdata  <= head_data;
            zero_flag <= (head_data == 32'd0);
            neg_flag  <= head_data[31];
        end else begin
            rf_we     <= 1'b0;
        end
    end

    assign rsv_vec = issue_valid ? (8'b1 << issue_dest) : 8'b0;
    assign rel_vec = do_pop      ? (8'b1 << head_dest)  : 8'b0;

    // A reserve and release of the same register at one edge cancel out.
    // Overflow saturates and underflow clamps at zero; both raise err.
    always_comb begin
        err_set = 1'b0;
        for (int i = 0; i < 8; i++) begin
            cnt_nxt[i] = cnt[i];
            if (rsv_vec[i] && !rel_vec[i]) begin
                if (cnt[i] == CNT_MAX) err_set = 1'b1;
                else                   cnt_nxt[i] = cnt[i] + CNT_W'(1);
            end else if (rel_vec[i] && !rsv_vec[i]) begin
                if (cnt[i] == '0) err_set = 1'b1;
                else              cnt_nxt[i] = cnt[i] - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 8; i++) cnt[i] <= '0;
            err <= 1'b0;
        end else begin
            cnt <= cnt_nxt;
            if (err_set) err <= 1'b1;
        end
    end

    always_comb begin
        pending_mask = 8'b0;
        for (int i = 0; i < 8; i++) pending_mask[i] = (cnt[i] != '0);
    end

endmodule
